fcvt_int2fp_pipe: RTL and testbench

Parametrised, flow-controlled integer-to-single-precision converter for the FPU pipeline. It converts a signed or unsigned XLEN-bit integer to IEEE-754 binary32 (fcvt.s.w / fcvt.s.wu, plus the .l/.lu forms when XLEN=64). It honours all five RISC-V static rounding modes and reports the inexact flag. It sits between the FPU issue logic and the FP writeback arbiter, with valid/ready handshakes on both sides and a sideband tag carried alongside each operation.

---
 rtl/fcvt_int2fp_pipe.sv | 161 ++++++++++++++++
 tb/tb_fcvt_int2fp_pipe.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_int2fp_pipe.sv
// Two-stage flow-controlled integer to binary32 converter (fcvt.s.w/wu/l/lu).
// Stage 1 captures sign, magnitude and leading-zero count; stage 2 normalises, rounds and packs.
module fcvt_int2fp_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_x,
    input  logic             in_unsigned,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_nx,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LZW = $clog2(XLEN + 1);

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    function automatic logic [LZW-1:0] lzc(input logic [XLEN-1:0] v);
        logic [LZW-1:0] cnt;
        logic           found;
        cnt   = '0;
        found = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            found = found | v[i];
            cnt   = cnt + {{(LZW-1){1'b0}}, ~found};
        end
        return cnt;
    endfunction

    logic             adv_s;
    logic             in_sign_s;
    logic [XLEN-1:0]  in_mag_s;

    logic             s1_valid_r;
    logic             s1_sign_r;
    logic             s1_zero_r;
    logic [XLEN-1:0]  s1_mag_r;
    logic [LZW-1:0]   s1_lz_r;
    logic [2:0]       s1_rm_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic [XLEN-2:0]  norm_s;
    logic [22:0]      frac_s;
    logic             guard_s;
    logic             sticky_s;
    logic             inc_s;
    logic             carry_s;
    logic [22:0]      mant_s;
    logic [7:0]       exp_s;
    logic [31:0]      y_s;
    logic             nx_s;

    logic             out_valid_r;
    logic [31:0]      out_y_r;
    logic             out_nx_r;
    logic [TAG_W-1:0] out_tag_r;

    // A single advance signal freezes the whole pipe, empty stages included.
    assign adv_s     = ~out_valid_r | out_ready;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign out_y     = out_y_r;
    assign out_nx    = out_nx_r;
    assign out_tag   = out_tag_r;

    // Stage 1 combinational: sign and magnitude (most negative value maps to 2^(XLEN-1)).
    always_comb begin
        in_sign_s = ~in_unsigned & in_x[XLEN-1];
        if (in_sign_s) begin
            in_mag_s = ~in_x + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            in_mag_s = in_x;
        end
    end

    // Stage 1 register: captures the operand only on an accepted transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_mag_r   <= '0;
            s1_lz_r    <= '0;
            s1_rm_r    <= 3'd0;
            s1_tag_r   <= '0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= in_sign_s;
                s1_zero_r <= (in_mag_s == {XLEN{1'b0}});
                s1_mag_r  <= in_mag_s;
                s1_lz_r   <= lzc(in_mag_s);
                s1_rm_r   <= in_rm;
                s1_tag_r  <= in_tag;
            end else begin
                s1_sign_r <= s1_sign_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 combinational: normalise (leading one dropped), round and pack.
    always_comb begin
        norm_s   = (XLEN-1)'(s1_mag_r << s1_lz_r);
        frac_s   = norm_s[XLEN-2 -: 23];
        guard_s  = norm_s[XLEN-25];
        sticky_s = |norm_s[XLEN-26:0];
        inc_s    = 1'b0;
        case (s1_rm_r)
            RM_RTZ:  inc_s = 1'b0;
            RM_RDN:  inc_s = s1_sign_r & (guard_s | sticky_s);
            RM_RUP:  inc_s = ~s1_sign_r & (guard_s | sticky_s);
            RM_RMM:  inc_s = guard_s;
            default: inc_s = guard_s & (sticky_s | frac_s[0]);
        endcase
        {carry_s, mant_s} = {1'b0, frac_s} + {23'd0, inc_s};
        // Largest exponent is 127+63+1 = 191, so no overflow path exists.
        exp_s = 8'd127 + 8'(XLEN - 1) - 8'(s1_lz_r) + {7'd0, carry_s};
        if (s1_zero_r) begin
            y_s  = 32'd0;
            nx_s = 1'b0;
        end else begin
            y_s  = {s1_sign_r, exp_s, mant_s};
            nx_s = guard_s | sticky_s;
        end
    end

    // Output register: results hold while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_y_r     <= 32'd0;
            out_nx_r    <= 1'b0;
            out_tag_r   <= '0;
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_y_r   <= y_s;
                out_nx_r  <= nx_s;
                out_tag_r <= s1_tag_r;
            end else begin
                out_y_r   <= out_y_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_fcvt_int2fp_pipe.sv
// Scoreboard bench for fcvt_int2fp_pipe: XLEN=32 and XLEN=64 instances sharing clock and reset.
module tb_fcvt_int2fp_pipe;

    typedef struct packed {
        logic [31:0] y;
        logic        nx;
        logic [4:0]  tag;
    } exp_t;

    typedef struct packed {
        logic [63:0] x;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] y;
        logic        nx;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic        in_valid, in_ready, in_unsigned, out_valid, out_ready, out_nx;
    logic [31:0] in_x, out_y;
    logic [2:0]  in_rm;
    logic [4:0]  in_tag, out_tag;

    logic        in_valid64, in_ready64, in_unsigned64, out_valid64, out_ready64, out_nx64;
    logic [63:0] in_x64;
    logic [31:0] out_y64;
    logic [2:0]  in_rm64;
    logic [4:0]  in_tag64, out_tag64;

    exp_t sb32[$];
    exp_t sb64[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fcvt_int2fp_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_unsigned(in_unsigned), .in_rm(in_rm), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_nx(out_nx), .out_tag(out_tag)
    );

    fcvt_int2fp_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid64), .in_ready(in_ready64), .in_x(in_x64),
        .in_unsigned(in_unsigned64), .in_rm(in_rm64), .in_tag(in_tag64), .out_valid(out_valid64),
        .out_ready(out_ready64), .out_y(out_y64), .out_nx(out_nx64), .out_tag(out_tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: locate the top set bit, then round the discarded remainder against half an ulp.
    function automatic logic [32:0] model(input logic [63:0] x, input int xl, input logic uns,
                                          input logic [2:0] rm);
        logic [63:0] mask, xm, m, q, rem, half;
        logic        s, inc;
        int          p, sh;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        xm   = x & mask;
        s    = !uns && xm[xl-1];
        m    = s ? ((~xm + 64'd1) & mask) : xm;
        if (m == 64'd0) return 33'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        if (p <= 23) return {1'b0, s, 8'(127 + p), 23'(m << (23 - p))};
        sh   = p - 23;
        q    = m >> sh;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s && (rem != 64'd0);
            3'd3:    inc = !s && (rem != 64'd0);
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && q[0]);
        endcase
        q = q + {63'd0, inc};
        if (q[24]) begin
            q = q >> 1;
            p = p + 1;
        end
        return {rem != 64'd0, s, 8'(127 + p), q[22:0]};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || out_y !== 32'd0 || out_nx !== 1'b0 || out_tag !== 5'd0 || out_valid64 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b y=%h nx=%b tag=%0d v64=%b, want 0/0/0/0/0",
                     out_valid, out_y, out_nx, out_tag, out_valid64);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_convert32();
        vec_t        v[$];
        int          idx = 0;
        int          cyc = 0;
        exp_t        e;
        logic [32:0] r;
        logic [63:0] x;
        logic        u;
        logic [2:0]  rm;
        v.push_back('{x:64'h0000_0000, uns:1'b0, rm:3'd0, y:32'h0000_0000, nx:1'b0});
        v.push_back('{x:64'hFFFF_FFFF, uns:1'b0, rm:3'd0, y:32'hBF80_0000, nx:1'b0});
        v.push_back('{x:64'h8000_0000, uns:1'b0, rm:3'd0, y:32'hCF00_0000, nx:1'b0});
        v.push_back('{x:64'h8000_0000, uns:1'b1, rm:3'd0, y:32'h4F00_0000, nx:1'b0});
        v.push_back('{x:64'h0100_0001, uns:1'b0, rm:3'd0, y:32'h4B80_0000, nx:1'b1});
        v.push_back('{x:64'h0100_0001, uns:1'b0, rm:3'd3, y:32'h4B80_0001, nx:1'b1});
        v.push_back('{x:64'h0100_0003, uns:1'b0, rm:3'd0, y:32'h4B80_0002, nx:1'b1});
        v.push_back('{x:64'hFFFF_FFFF, uns:1'b1, rm:3'd0, y:32'h4F80_0000, nx:1'b1});
        v.push_back('{x:64'hFFFF_FFFF, uns:1'b1, rm:3'd1, y:32'h4F7F_FFFF, nx:1'b1});
        v.push_back('{x:64'hFFFF_FFFF, uns:1'b0, rm:3'd2, y:32'hBF80_0000, nx:1'b0});
        v.push_back('{x:64'h0000_0000, uns:1'b0, rm:3'd2, y:32'h0000_0000, nx:1'b0});
        v.push_back('{x:64'h0100_0001, uns:1'b0, rm:3'd4, y:32'h4B80_0001, nx:1'b1});
        v.push_back('{x:64'h0100_0003, uns:1'b0, rm:3'd7, y:32'h4B80_0002, nx:1'b1});
        v.push_back('{x:64'h7FFF_FFFF, uns:1'b0, rm:3'd1, y:32'h4EFF_FFFF, nx:1'b1});
        v.push_back('{x:64'h7FFF_FFFF, uns:1'b0, rm:3'd0, y:32'h4F00_0000, nx:1'b1});
        v.push_back('{x:64'h0000_0001, uns:1'b0, rm:3'd0, y:32'h3F80_0000, nx:1'b0});
        for (int i = 0; i < 40; i++) begin
            x  = {32'd0, $urandom >> $urandom_range(0, 31)};
            u  = 1'($urandom_range(0, 1));
            rm = 3'($urandom_range(0, 7));
            r  = model(x, 32, u, rm);
            v.push_back('{x:x, uns:u, rm:rm, y:r[31:0], nx:r[32]});
        end
        out_ready = 1'b1;
        while ((idx < v.size() || sb32.size() != 0) && cyc < 2000) begin
            if (idx < v.size()) begin
                in_valid    = 1'b1;
                in_x        = v[idx].x[31:0];
                in_unsigned = v[idx].uns;
                in_rm       = v[idx].rm;
                in_tag      = 5'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                sb32.push_back('{y:v[idx].y, nx:v[idx].nx, tag:in_tag});
                idx++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb32.size() == 0) begin
                    n_bad++;
                    $display("FAIL conv32_extra: got y=%h with nothing expected", out_y);
                end else begin
                    e = sb32.pop_front();
                    if (out_y !== e.y || out_nx !== e.nx || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL conv32: got y=%h nx=%b tag=%0d want y=%h nx=%b tag=%0d",
                                 out_y, out_nx, out_tag, e.y, e.nx, e.tag);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (cyc >= 2000) begin
            n_bad++;
            $display("FAIL conv32_timeout: got %0d pending want 0", sb32.size());
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          got  = 0;
        int          c    = 0;
        logic        held = 1'b0;
        logic [31:0] hy;
        logic        hnx;
        logic [4:0]  htag;
        exp_t        e;
        logic [32:0] r;
        while (got < 6 && c < 200) begin
            out_ready = !(c >= 4 && c < 7);
            if (sent < 6) begin
                in_valid    = 1'b1;
                in_x        = $urandom;
                in_unsigned = 1'($urandom_range(0, 1));
                in_rm       = 3'(sent % 5);
                in_tag      = 5'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_y !== hy || out_nx !== hnx || out_tag !== htag) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b y=%h nx=%b tag=%0d want v=1 y=%h nx=%b tag=%0d",
                             out_valid, out_y, out_nx, out_tag, hy, hnx, htag);
                end
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
                held = 1'b1;
                hy   = out_y;
                hnx  = out_nx;
                htag = out_tag;
            end
            if (in_valid && in_ready) begin
                r = model({32'd0, in_x}, 32, in_unsigned, in_rm);
                sb32.push_back('{y:r[31:0], nx:r[32], tag:in_tag});
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb32.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra: got tag=%0d with nothing expected", out_tag);
                end else begin
                    e = sb32.pop_front();
                    if (out_y !== e.y || out_nx !== e.nx || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL b2b: got y=%h nx=%b tag=%0d want y=%h nx=%b tag=%0d",
                                 out_y, out_nx, out_tag, e.y, e.nx, e.tag);
                    end
                end
                got++;
            end
            @(negedge clk);
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != 6) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results want 6", got);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [32:0] r;
        out_ready   = 1'b1;
        in_unsigned = 1'b0;
        in_rm       = 3'd0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = 32'h0000_1234 + 32'(i);
            in_tag   = 5'(20 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_preload: got out_valid=%b want 1", out_valid);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_y !== 32'd0 || out_nx !== 1'b0 || out_tag !== 5'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_async: got v=%b y=%h nx=%b tag=%0d rdy=%b want 0/0/0/0/1",
                     out_valid, out_y, out_nx, out_tag, in_ready);
        end
        sb32.delete();
        in_valid = 1'b1;
        in_x     = 32'h0000_0777;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rstn     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_stale: got out_valid=%b tag=%0d want 0", out_valid, out_tag);
            end
        end
        in_valid    = 1'b1;
        in_x        = 32'hFFFF_FF00;
        in_unsigned = 1'b0;
        in_rm       = 3'd2;
        in_tag      = 5'd9;
        r           = model({32'd0, in_x}, 32, 1'b0, 3'd2);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_latency1: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_y !== r[31:0] || out_nx !== r[32] || out_tag !== 5'd9) begin
            n_bad++;
            $display("FAIL rst_latency2: got v=%b y=%h nx=%b tag=%0d want v=1 y=%h nx=%b tag=9",
                     out_valid, out_y, out_nx, out_tag, r[31:0], r[32]);
        end
        @(negedge clk);
    endtask

    task automatic test_xlen64();
        vec_t        v[$];
        int          idx = 0;
        int          cyc = 0;
        exp_t        e;
        logic [32:0] r;
        logic [63:0] x;
        logic        u;
        logic [2:0]  rm;
        v.push_back('{x:64'hFFFF_FFFF_FFFF_FFFF, uns:1'b1, rm:3'd0, y:32'h5F80_0000, nx:1'b1});
        v.push_back('{x:64'h8000_0000_0000_0000, uns:1'b0, rm:3'd0, y:32'hDF00_0000, nx:1'b0});
        v.push_back('{x:64'hFFFF_FFFF_FFFF_FFFF, uns:1'b0, rm:3'd3, y:32'hBF80_0000, nx:1'b0});
        for (int i = 0; i < 60; i++) begin
            x  = {$urandom, $urandom} >> $urandom_range(0, 63);
            u  = 1'($urandom_range(0, 1));
            rm = 3'($urandom_range(0, 7));
            r  = model(x, 64, u, rm);
            v.push_back('{x:x, uns:u, rm:rm, y:r[31:0], nx:r[32]});
        end
        while ((idx < v.size() || sb64.size() != 0) && cyc < 2000) begin
            out_ready64 = ($urandom_range(0, 3) != 0);
            if (idx < v.size()) begin
                in_valid64    = 1'b1;
                in_x64        = v[idx].x;
                in_unsigned64 = v[idx].uns;
                in_rm64       = v[idx].rm;
                in_tag64      = 5'($urandom);
            end else begin
                in_valid64 = 1'b0;
            end
            #1;
            if (in_valid64 && in_ready64) begin
                sb64.push_back('{y:v[idx].y, nx:v[idx].nx, tag:in_tag64});
                idx++;
            end
            if (out_valid64 && out_ready64) begin
                n_cmp++;
                if (sb64.size() == 0) begin
                    n_bad++;
                    $display("FAIL conv64_extra: got y=%h with nothing expected", out_y64);
                end else begin
                    e = sb64.pop_front();
                    if (out_y64 !== e.y || out_nx64 !== e.nx || out_tag64 !== e.tag) begin
                        n_bad++;
                        $display("FAIL conv64: got y=%h nx=%b tag=%0d want y=%h nx=%b tag=%0d",
                                 out_y64, out_nx64, out_tag64, e.y, e.nx, e.tag);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid64 = 1'b0;
        n_cmp++;
        if (cyc >= 2000) begin
            n_bad++;
            $display("FAIL conv64_timeout: got %0d pending want 0", sb64.size());
        end
    endtask

    initial begin
        rstn          = 1'b0;
        in_valid      = 1'b0;
        in_x          = 32'd0;
        in_unsigned   = 1'b0;
        in_rm         = 3'd0;
        in_tag        = 5'd0;
        out_ready     = 1'b1;
        in_valid64    = 1'b0;
        in_x64        = 64'd0;
        in_unsigned64 = 1'b0;
        in_rm64       = 3'd0;
        in_tag64      = 5'd0;
        out_ready64   = 1'b1;
        test_reset();
        test_convert32();
        test_back_to_back();
        test_reset_mid_op();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
